// File: rtl/vco_adc_pkg.sv
// vco_adc_pkg: shared types and defaults
// for the multi-channel VCO ADC array.
package vco_adc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int WIN_W_DEF  = 16;

  localparam logic [CNT_W_DEF-1:0] SAT_VAL =
    {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/vco_adc_array_edge.sv
// vco_edge_counter: synchronizes one VCO line
// and counts its rising edges with saturation.
module vco_edge_counter
  import vco_adc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vco,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat_nxt
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [2:0]       sh;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             rise;

  assign rise = sh[1] & ~sh[2];

  // count including this cycle's edge, clipped at full scale
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat;
    if (rise) begin
      if (cnt == SAT) sat_nxt = 1'b1;
      else cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // two-flop sync, edge-detect flop, counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      sh <= {sh[1:0], vco};
      if (clr) begin
        cnt <= '0;
        sat <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        sat <= sat_nxt;
      end
    end
  end

endmodule

// File: rtl/vco_adc_array.sv
// vco_adc_array: windowed edge counting over
// NUM_CH VCOs, snapshot and per-channel drain.
module vco_adc_array
  import vco_adc_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int CH_W   =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_CH-1:0] vco_i,
  input  logic              enable_i,
  input  logic              continuous_i,
  input  logic              start_i,
  input  logic [WIN_W-1:0]  window_i,
  input  logic [NUM_CH-1:0] chan_mask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  out_data_o,
  output logic [CH_W-1:0]   out_chan_o,
  output logic              out_sat_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              overflow_o
);

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   win, win_nxt;
  logic               clr, snap;

  logic [CNT_W-1:0]   cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  sat_nxt;

  logic [CNT_W-1:0]   sh_data [NUM_CH];
  logic [NUM_CH-1:0]  sh_sat, sh_mask;
  logic               drain;
  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    first_idx, next_idx;
  logic               has_next;
  logic               fire, accept;
  logic               ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vco_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .vco     (vco_i[g]),
      .clr     (clr),
      .cnt_nxt (cnt_nxt[g]),
      .sat_nxt (sat_nxt[g])
    );
  end

  // window FSM: counters stay cleared outside a live window
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    clr       = 1'b0;
    snap      = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (start_i && enable_i) begin
          state_nxt = COUNT;
          win_nxt   = window_i;
        end
      end
      COUNT: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (win == '0) begin
          snap = 1'b1;
          clr  = 1'b1;
          if (continuous_i) win_nxt = window_i;
          else state_nxt = IDLE;
        end else begin
          win_nxt = win - WIN_W'(1);
        end
      end
    endcase
  end

  // FSM state and window down-counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      win   <= '0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
    end
  end

  // lowest channel of the incoming mask
  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (chan_mask_i[i]) first_idx = CH_W'(i);
  end

  // next latched channel above the drain pointer
  always_comb begin
    next_idx = ptr;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (sh_mask[i] && i > int'(ptr)) begin
        next_idx = CH_W'(i);
        has_next = 1'b1;
      end
  end

  assign fire   = drain & out_ready_i;
  assign accept = snap & ~drain & (|chan_mask_i);

  // shadow capture, drain walk, sticky drop flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CH; i++)
        sh_data[i] <= '0;
      sh_sat  <= '0;
      sh_mask <= '0;
      drain   <= 1'b0;
      ptr     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (snap && drain) ovf <= 1'b1;
      if (accept) begin
        for (int i = 0; i < NUM_CH; i++)
          sh_data[i] <= cnt_nxt[i];
        sh_sat  <= sat_nxt;
        sh_mask <= chan_mask_i;
        ptr     <= first_idx;
        drain   <= 1'b1;
      end else if (fire) begin
        if (has_next) ptr <= next_idx;
        else drain <= 1'b0;
      end
    end
  end

  assign out_valid_o = drain;
  assign out_data_o  = sh_data[ptr];
  assign out_chan_o  = ptr;
  assign out_sat_o   = sh_sat[ptr];
  assign out_last_o  = drain & ~has_next;
  assign busy_o      = (state == COUNT);
  assign overflow_o  = ovf;

endmodule

// File: doc/vco_adc_array.md
# vco_adc_array

Multi-channel successor to the single-channel VCO ADC wrapper in the Caravel user project area. It counts rising edges of NUM_CH asynchronous VCO outputs over a programmable conversion window and snapshots all channels simultaneously at the window end. The snapshot is streamed one channel per beat over a valid/ready interface to the Wishbone-side register logic. It supports single-shot and continuous modes, a per-channel mask, count saturation and sticky frame-drop detection.

## Interface
Parameters:
- NUM_CH, 4, number of VCO channels (1..16)
- CNT_W, 16, edge-counter and result width
- WIN_W, 16, window-length field width
- CH_W, $clog2(NUM_CH) (min 1), channel-index width

Ports:
- wb_clk_i  in  1  single system clock
- wb_rst_i  in  1  reset, synchronous, active-high
- vco_i  in  NUM_CH  raw VCO outputs, asynchronous; f_vco < f_clk/2 required
- enable_i  in  1  block enable; low aborts counting
- continuous_i  in  1  0 = single-shot, 1 = back-to-back windows
- start_i  in  1  one-cycle start pulse
- window_i  in  WIN_W  window length minus one, in clock cycles
- chan_mask_i  in  NUM_CH  channels included in the output frame
- out_valid_o  out  1  result beat valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  CNT_W  edge count for out_chan_o
- out_chan_o  out  CH_W  channel index of the beat
- out_sat_o  out  1  count saturated during that window
- out_last_o  out  1  last beat of the frame
- busy_o  out  1  counting FSM not IDLE
- overflow_o  out  1  sticky: a completed window was dropped

## Operation
- Reset values: all outputs 0, FSM IDLE, counters 0, snapshot empty, overflow_o 0.
- FSM states: IDLE, COUNT.
  - IDLE -> COUNT on start_i & enable_i. Loads the window counter from window_i and clears the edge counters.
  - COUNT, terminal cycle (window counter = 0): snapshot taken. Continuous mode: stays in COUNT, reloads from window_i and clears counters. Single-shot: goes to IDLE.
  - COUNT -> IDLE when enable_i = 0: counters cleared, no snapshot. A frame already draining completes.
  - start_i is ignored in COUNT.
- Per channel: 2-flop synchronizer, then a rising-edge detect flop, then a saturating counter.
  - The counter holds at 2^CNT_W-1 and sets that channel's sat bit.
- Snapshot: on the terminal cycle, count values (including any edge in that cycle), sat bits and chan_mask_i are latched into the shadow registers.
  - If the shadow is still draining, the new window is dropped, overflow_o is set and the shadow is unchanged.
  - If the latched mask is all-zero, no frame is produced and overflow_o is not set.
- Drain: masked channels are emitted in ascending index order, one per handshake (out_valid_o & out_ready_i).
  - out_last_o is high on the highest masked channel.
  - out_data_o, out_chan_o, out_sat_o and out_last_o stay stable while out_valid_o & !out_ready_i.
  - The shadow is free in the cycle after the last handshake. A snapshot in that same cycle as the last handshake counts as overflow.
- overflow_o is cleared only by wb_rst_i.

## Timing
- Edge-to-count latency: 3 cycles from a vco_i rising edge to the counter increment.
- Window: exactly window_i+1 cycles. Next window starts the following cycle with no gap; window_i is resampled at each reload.
- Snapshot to first out_valid_o: 1 cycle.
- Throughput: one beat per cycle while out_ready_i is high.
- wb_rst_i is asserted mid-frame or mid-window: all state returns to reset values on the next edge.

## Structure
- Package vco_adc_pkg holds:
  - the FSM state enum (IDLE, COUNT);
  - parameter defaults;
  - a localparam for the saturation value.
- Sub-module vco_edge_counter (synchronizer, edge detect, saturating counter, clear input), instantiated NUM_CH times.
- The top level holds the window counter, FSM, shadow registers and drain pointer.

## Test plan
- Single-shot: NUM_CH=4, window_i=99, square waves on ch0..3 with periods 4/6/10/20 clocks, mask 4'hF. Expect 4 beats: chan 0..3, data ≈25/16-17/10/5, last on chan 3, then busy_o=0.
- Continuous with out_ready_i held high, window_i=49, 8-clock period on all channels. Every frame is 4 beats of 6-7, no gaps between windows, overflow_o stays 0.
- Backpressure: out_ready_i=0 for 200 cycles with window_i=49, continuous. Expect overflow_o=1, first frame unchanged and stable, delivered intact when ready returns.
- Saturation: CNT_W=4, window_i=99, 4-clock period. Expect out_data_o=15 and out_sat_o=1.
- Mask 4'b1010: beats only for chan 1 and 3, out_last_o on chan 3. Mask 0: no out_valid_o at all.
- Abort and reset: enable_i dropped mid-window gives no frame and busy_o=0 the next cycle. wb_rst_i pulsed mid-drain gives all outputs 0 the next cycle.
